// File: rtl/spi_slave_param.sv
// Parametrised SPI slave: configurable word width, CPOL/CPHA, bit order and
// back-to-back words per frame, with a valid-pulse RX port and a one-deep TX holding register.
module spi_slave_param #(
  parameter int DATA_W      = 8,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs,
  output logic              miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_underrun,
  output logic              frame_err,
  output logic              busy
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_real;

  logic [0:0]        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] tx_shifted;
  logic [DATA_W-1:0] hold_data;
  logic              hold_full;
  logic              load_pending;

  logic cs_s, mosi_s, cs_fall, cs_rise;
  logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic active, start, stop, do_shift, do_load;

  // cs_real marks which cs stages hold genuine samples, so the reset value
  // of the synchroniser can never fake a chip-select fall.
  // NOTE: every flop is written with <= so all stages update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= {SYNC_STAGES{CPOL}};
      cs_sync   <= '1;
      mosi_sync <= '0;
      cs_real   <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_real   <= {cs_real[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign cs_fall = cs_real[SYNC_STAGES-1] & cs_s & ~cs_sync[SYNC_STAGES-2];
  assign cs_rise = ~cs_s & cs_sync[SYNC_STAGES-2];

  assign sclk_rise = ~sclk_sync[SYNC_STAGES-1] &  sclk_sync[SYNC_STAGES-2];
  assign sclk_fall =  sclk_sync[SYNC_STAGES-1] & ~sclk_sync[SYNC_STAGES-2];

  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;

  // A cs rise in the same cycle as an sclk edge wins; the edge is dropped.
  assign active   = (state == ACTIVE);
  assign start    = (state == IDLE) & cs_fall;
  assign stop     = active & cs_rise;
  assign do_shift = active & ~cs_rise & shift_edge;
  assign do_load  = (start & ~CPHA) | (do_shift & load_pending);

  assign rx_next    = MSB_FIRST ? {rx_sr[DATA_W-2:0], mosi_s} : {mosi_s, rx_sr[DATA_W-1:1]};
  assign tx_shifted = MSB_FIRST ? {tx_sr[DATA_W-2:0], 1'b0}   : {1'b0, tx_sr[DATA_W-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      rx_sr        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      frame_err    <= 1'b0;
      load_pending <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= ACTIVE;
            bit_cnt      <= '0;
            load_pending <= CPHA;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state        <= IDLE;
            frame_err    <= (bit_cnt != '0);
            bit_cnt      <= '0;
            load_pending <= 1'b0;
          end else if (sample_edge) begin
            rx_sr <= rx_next;
            if (bit_cnt == LAST_BIT) begin
              rx_data      <= rx_next;
              rx_valid     <= 1'b1;
              bit_cnt      <= '0;
              load_pending <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end else if (shift_edge && load_pending) begin
            load_pending <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A load with the holding register empty sends zeros and flags an underrun;
  // a word offered in that same cycle is kept for the following load.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_sr       <= '0;
      hold_full   <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= do_load & ~hold_full;
      if (stop) begin
        tx_sr <= '0;
      end else if (do_load) begin
        tx_sr <= hold_full ? hold_data : '0;
      end else if (do_shift) begin
        tx_sr <= tx_shifted;
      end
      if (tx_valid && tx_ready) begin
        hold_full <= 1'b1;
      end else if (do_load) begin
        hold_full <= 1'b0;
      end
    end
  end

  // NOTE: hold_data has no reset; hold_full alone says whether it is meaningful.
  always_ff @(posedge clk) begin
    if (tx_valid && tx_ready) begin
      hold_data <= tx_data;
    end
  end

  assign tx_ready = ~hold_full;
  assign busy     = active;
  assign miso     = cs_s ? 1'bz : (MSB_FIRST ? tx_sr[DATA_W-1] : tx_sr[0]);

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param: five instances cover modes 0-3, a
// 16-bit word and LSB-first order, driven by one shared sclk/mosi master.
`timescale 1ns/1ps
module tb_spi_slave_param;

  localparam int H = 8;  // sclk half period in clk cycles

  logic        clk = 1'b0;
  logic        reset;
  logic        sclk;
  logic        mosi;
  logic [4:0]  cs;
  logic [4:0]  tx_valid;
  logic [15:0] tx_data;

  wire         miso0, miso1, miso2, miso3, miso4;
  logic [7:0]  rx_data0, rx_data2, rx_data3, rx_data4;
  logic [15:0] rx_data1;
  logic [4:0]  rx_valid, tx_ready, tx_underrun, frame_err, busy;

  int passed = 0;
  int total  = 0;
  int rxv_cnt[5]  = '{default: 0};
  int und_cnt[5]  = '{default: 0};
  int ferr_cnt[5] = '{default: 0};
  logic [7:0] rx_log2[4];

  int b_rx, b_und, b_fe;
  logic [15:0] din;

  always #5 clk = ~clk;

  spi_slave_param #(.DATA_W(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)) u_m0 (
    .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .cs(cs[0]), .miso(miso0),
    .rx_data(rx_data0), .rx_valid(rx_valid[0]), .tx_data(tx_data[7:0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .tx_underrun(tx_underrun[0]), .frame_err(frame_err[0]), .busy(busy[0]));

  spi_slave_param #(.DATA_W(16), .CPOL(1), .CPHA(1), .MSB_FIRST(1), .SYNC_STAGES(2)) u_m3 (
    .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .cs(cs[1]), .miso(miso1),
    .rx_data(rx_data1), .rx_valid(rx_valid[1]), .tx_data(tx_data), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .tx_underrun(tx_underrun[1]), .frame_err(frame_err[1]), .busy(busy[1]));

  spi_slave_param #(.DATA_W(8), .CPOL(0), .CPHA(1), .MSB_FIRST(1), .SYNC_STAGES(2)) u_m1 (
    .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .cs(cs[2]), .miso(miso2),
    .rx_data(rx_data2), .rx_valid(rx_valid[2]), .tx_data(tx_data[7:0]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .tx_underrun(tx_underrun[2]), .frame_err(frame_err[2]), .busy(busy[2]));

  spi_slave_param #(.DATA_W(8), .CPOL(1), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)) u_m2 (
    .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .cs(cs[3]), .miso(miso3),
    .rx_data(rx_data3), .rx_valid(rx_valid[3]), .tx_data(tx_data[7:0]), .tx_valid(tx_valid[3]),
    .tx_ready(tx_ready[3]), .tx_underrun(tx_underrun[3]), .frame_err(frame_err[3]), .busy(busy[3]));

  spi_slave_param #(.DATA_W(8), .CPOL(0), .CPHA(0), .MSB_FIRST(0), .SYNC_STAGES(2)) u_lsb (
    .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .cs(cs[4]), .miso(miso4),
    .rx_data(rx_data4), .rx_valid(rx_valid[4]), .tx_data(tx_data[7:0]), .tx_valid(tx_valid[4]),
    .tx_ready(tx_ready[4]), .tx_underrun(tx_underrun[4]), .frame_err(frame_err[4]), .busy(busy[4]));

  always @(posedge clk) begin
    if (rx_valid[2]) rx_log2[rxv_cnt[2] % 4] <= rx_data2;
    for (int i = 0; i < 5; i++) begin
      if (rx_valid[i])    rxv_cnt[i]  <= rxv_cnt[i] + 1;
      if (tx_underrun[i]) und_cnt[i]  <= und_cnt[i] + 1;
      if (frame_err[i])   ferr_cnt[i] <= ferr_cnt[i] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put_tx(input int idx, input logic [15:0] d);
    tx_data       = d;
    tx_valid[idx] = 1'b1;
    wait_clk(1);
    tx_valid[idx] = 1'b0;
  endtask

  function automatic logic get_miso(input int idx);
    case (idx)
      0:       return miso0;
      1:       return miso1;
      2:       return miso2;
      3:       return miso3;
      default: return miso4;
    endcase
  endfunction

  task automatic snap(input int idx);
    b_rx  = rxv_cnt[idx];
    b_und = und_cnt[idx];
    b_fe  = ferr_cnt[idx];
  endtask

  task automatic frame_begin(input int idx, input bit cpol);
    sclk = cpol;
    wait_clk(H);
    cs[idx] = 1'b0;
    wait_clk(H);
  endtask

  task automatic frame_end(input int idx);
    wait_clk(H);
    cs[idx] = 1'b1;
    wait_clk(2 * H);
  endtask

  // Master side: drives mosi, generates sclk and samples miso on the sample edge.
  task automatic xfer_word(input int idx, input bit cpol, input bit cpha, input bit msb,
                           input int nbits, input logic [15:0] dout, output logic [15:0] d_in);
    d_in = '0;
    for (int b = 0; b < nbits; b++) begin
      int pos;
      pos = msb ? (nbits - 1 - b) : b;
      if (!cpha) begin
        mosi = dout[pos];
        wait_clk(H);
        d_in[pos] = get_miso(idx);
        sclk = ~cpol;
        wait_clk(H);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = dout[pos];
        wait_clk(H);
        d_in[pos] = get_miso(idx);
        sclk = cpol;
        wait_clk(H);
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    cs       = '1;
    sclk     = 1'b0;
    mosi     = 1'b0;
    tx_valid = '0;
    tx_data  = '0;
    wait_clk(4);
    reset = 1'b0;
    wait_clk(2 * H);

    check("reset_tx_ready", tx_ready, 5'h1f);
    check("reset_busy", busy, 5'h00);
    check("reset_flags", {rx_valid, tx_underrun, frame_err}, 15'h0000);
    check("reset_rx_data", {rx_data0, rx_data1}, 24'h000000);

    // Mode 0, 8-bit: tx 0xA5, rx 0x3C
    put_tx(0, 16'h00A5);
    check("t1_tx_ready_drop", tx_ready[0], 1'b0);
    snap(0);
    frame_begin(0, 1'b0);
    check("t1_busy", busy[0], 1'b1);
    check("t1_no_underrun_at_load", und_cnt[0] - b_und, 0);
    check("t1_tx_ready_back", tx_ready[0], 1'b1);
    xfer_word(0, 1'b0, 1'b0, 1'b1, 8, 16'h003C, din);
    frame_end(0);
    check("t1_rx_data", rx_data0, 8'h3C);
    check("t1_rx_valid_count", rxv_cnt[0] - b_rx, 1);
    check("t1_master_read", din, 16'h00A5);
    check("t1_no_frame_err", ferr_cnt[0] - b_fe, 0);
    check("t1_busy_clear", busy[0], 1'b0);

    // Mode 3, 16-bit: tx 0xBEEF, rx 0x1234
    put_tx(1, 16'hBEEF);
    snap(1);
    frame_begin(1, 1'b1);
    xfer_word(1, 1'b1, 1'b1, 1'b1, 16, 16'h1234, din);
    frame_end(1);
    check("t2_rx_data", rx_data1, 16'h1234);
    check("t2_master_read", din, 16'hBEEF);
    check("t2_rx_valid_count", rxv_cnt[1] - b_rx, 1);
    check("t2_no_underrun", und_cnt[1] - b_und, 0);

    // Mode 1, two words in one frame
    put_tx(2, 16'h0011);
    snap(2);
    frame_begin(2, 1'b0);
    xfer_word(2, 1'b0, 1'b1, 1'b1, 8, 16'h00C3, din);
    check("t3_master_read_w0", din, 16'h0011);
    check("t3_tx_ready_mid", tx_ready[2], 1'b1);
    put_tx(2, 16'h0022);
    xfer_word(2, 1'b0, 1'b1, 1'b1, 8, 16'h005A, din);
    check("t3_master_read_w1", din, 16'h0022);
    frame_end(2);
    check("t3_rx_valid_count", rxv_cnt[2] - b_rx, 2);
    check("t3_rx_word0", rx_log2[b_rx % 4], 8'hC3);
    check("t3_rx_word1", rx_log2[(b_rx + 1) % 4], 8'h5A);
    check("t3_no_underrun", und_cnt[2] - b_und, 0);

    // Mode 0, holding register empty at the cs-fall load
    snap(0);
    frame_begin(0, 1'b0);
    check("t4_underrun_at_load", und_cnt[0] - b_und, 1);
    xfer_word(0, 1'b0, 1'b0, 1'b1, 8, 16'h00FF, din);
    frame_end(0);
    check("t4_master_read", din, 16'h0000);
    check("t4_rx_data", rx_data0, 8'hFF);

    // Mode 2: abort after 5 sclk cycles, then a full frame
    snap(3);
    frame_begin(3, 1'b1);
    xfer_word(3, 1'b1, 1'b0, 1'b1, 5, 16'h001F, din);
    frame_end(3);
    check("t5_frame_err", ferr_cnt[3] - b_fe, 1);
    check("t5_no_rx_valid", rxv_cnt[3] - b_rx, 0);
    check("t5_rx_data_kept", rx_data3, 8'h00);
    snap(3);
    frame_begin(3, 1'b1);
    xfer_word(3, 1'b1, 1'b0, 1'b1, 8, 16'h0096, din);
    frame_end(3);
    check("t5_rx_data_next", rx_data3, 8'h96);
    check("t5_next_no_frame_err", ferr_cnt[3] - b_fe, 0);
    check("t5_next_rx_valid", rxv_cnt[3] - b_rx, 1);

    // LSB-first: tx 0x80 appears as 0,0,0,0,0,0,0,1 on the wire
    put_tx(4, 16'h0080);
    frame_begin(4, 1'b0);
    xfer_word(4, 1'b0, 1'b0, 1'b0, 8, 16'h0001, din);
    frame_end(4);
    check("t6_rx_data", rx_data4, 8'h01);
    check("t6_master_stream", din, 16'h0080);

    // Reset in the middle of a frame, with cs held low afterwards
    put_tx(0, 16'h005A);
    frame_begin(4, 1'b0);
    xfer_word(4, 1'b0, 1'b0, 1'b0, 3, 16'h0005, din);
    check("t6_busy_before_reset", busy[4], 1'b1);
    reset = 1'b1;
    wait_clk(1);
    check("t6_reset_busy", busy, 5'h00);
    check("t6_reset_tx_ready", tx_ready, 5'h1f);
    check("t6_reset_flags", {rx_valid, tx_underrun, frame_err}, 15'h0000);
    check("t6_reset_rx_data", {rx_data4, rx_data3, rx_data0}, 24'h000000);
    reset = 1'b0;
    wait_clk(4 * H);
    check("t6_no_frame_without_cs_fall", busy[4], 1'b0);
    cs[4] = 1'b1;
    wait_clk(2 * H);
    cs[4] = 1'b0;
    wait_clk(H);
    check("t6_new_frame_after_fall", busy[4], 1'b1);
    frame_end(4);
    check("t6_busy_end", busy[4], 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spi_slave_param.md
Name: spi_slave_param

Overview:
Parametrised successor to the team's fixed 8-bit, mode-0 SPI slave. Supports configurable word width, all four CPOL/CPHA modes, MSB/LSB-first order, and back-to-back words within one chip-select frame. Sits between an external SPI master and an internal system bus. Exposes a valid-pulse RX interface and a one-deep valid/ready TX holding register. Reports TX underrun and aborted frames.

Parameters:
DATA_W, 8, word width in bits (2..32)
CPOL, 0, sclk idle level
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
MSB_FIRST, 1, 1 = MSB shifted first, 0 = LSB first
SYNC_STAGES, 2, synchroniser depth for sclk/cs/mosi (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sclk  in  1  SPI clock from master (asynchronous)
mosi  in  1  master-out data (asynchronous)
cs  in  1  chip select, active low (asynchronous)
miso  out  1  slave-out data; high-Z when synced cs is high
rx_data  out  DATA_W  last complete received word
rx_valid  out  1  1-cycle pulse: rx_data updated
tx_data  in  DATA_W  word to transmit
tx_valid  in  1  tx_data offered
tx_ready  out  1  holding register empty
tx_underrun  out  1  1-cycle pulse: word load with empty holding register
frame_err  out  1  1-cycle pulse: cs deasserted mid-word
busy  out  1  frame active (synced cs low)

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high.
- Reset values:
  - Synchronisers: sclk = CPOL, cs = 1, mosi = 0.
  - State = IDLE; rx_data = 0; holding register empty.
  - Outputs: tx_ready = 1, rx_valid = 0, tx_underrun = 0, frame_err = 0, busy = 0, miso = Z.
- Synchronisation and edge detection:
  - sclk, cs and mosi each pass through SYNC_STAGES flops.
  - Edges are detected from the last two sclk stages.
  - mosi uses the same depth as sclk, so the sampled data stays aligned to the detected edge.
- Edge definitions:
  - Leading edge: rising if CPOL=0, falling if CPOL=1.
  - Sample edge: leading if CPHA=0, trailing if CPHA=1. The shift edge is the other one.
- Timing requirement: sclk high and low phases each ≥ SYNC_STAGES+2 clk periods. Behaviour is undefined otherwise.
- TX holding register:
  - Accepts a word when tx_valid & tx_ready. tx_ready drops the next cycle.
  - Emptied on each word load; tx_ready rises the cycle after the load.
  - No bypass: if tx_valid arrives in the same cycle as a load with the register empty, that load is an underrun and the new word is captured for the next load.
- Word load into the shift register (tx_sr):
  - Loads the holding word, or all zeros with a tx_underrun pulse if the holding register is empty.
  - CPHA=0: loads at synced cs fall and at the first shift edge after each word boundary.
  - CPHA=1: loads at the first leading (shift) edge of each word.
- miso drives tx_sr[DATA_W-1] if MSB_FIRST, otherwise tx_sr[0].
- Non-load shift edges shift tx_sr toward the output bit, filling with 0.
- States: IDLE and ACTIVE.
  - IDLE -> ACTIVE on synced cs fall: bit_cnt = 0, busy = 1.
  - ACTIVE, sample edge: shift mosi into rx_sr (into the LSB if MSB_FIRST, otherwise into the MSB); bit_cnt++.
  - ACTIVE, sample edge with bit_cnt == DATA_W-1: rx_data <= completed word, rx_valid pulses the next cycle, bit_cnt = 0, a load is pending for the next word; state stays ACTIVE.
  - ACTIVE -> IDLE on synced cs rise:
    - If bit_cnt != 0, pulse frame_err and discard the partial rx word (no rx_valid); rx_data is unchanged.
    - Any loaded but unsent tx_sr content is dropped; the holding register is untouched.
    - busy = 0.
- rx_data holds its value until the next complete word. There is no RX backpressure.
- A sample edge and a cs rise in the same cycle: the edge is ignored and the cs rise wins.
- Reset during a frame: return to the reset values immediately. The first frame after reset starts only on a new synced cs fall.

Test Plan:
1. Mode 0, DATA_W=8, preload tx 0xA5, master sends 0x3C in one frame -> rx_data=0x3C, exactly one rx_valid pulse, master reads 0xA5, tx_ready returns to 1, no errors.
2. Mode 3, DATA_W=16, tx 0xBEEF, master sends 0x1234 -> rx_data=0x1234, master reads 0xBEEF.
3. Mode 1, two back-to-back words in one frame, tx 0x11 then 0x22 (second written after tx_ready rises), master sends 0xC3, 0x5A -> two rx_valid pulses with 0xC3 then 0x5A, master reads 0x11, 0x22.
4. Mode 0, no tx word written, master sends 0xFF -> tx_underrun pulses once at the load, master reads 0x00, rx_data=0xFF.
5. Mode 2, cs raised after 5 sclk cycles -> frame_err pulse, no rx_valid, rx_data unchanged; the next full frame receiving 0x96 gives rx_data=0x96.
6. MSB_FIRST=0, master sends 0x01 LSB-first, tx 0x80 -> rx_data=0x01, master receives bit stream 0,0,0,0,0,0,0,1; reset mid-frame -> all outputs return to reset values next cycle.
